// File: rtl/posi_mpm_rate_est.sv
// Intra-mode rate estimator: per-CTU top/left neighbour-mode line buffers feed a
// 3-candidate MPM derivation, returning lambda-weighted mode bits two cycles after a query.

module posi_mpm_lbuf_ent #(
  parameter int MODE_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [MODE_W-1:0] d,
  output logic [MODE_W-1:0] q
);
  // Clear beats write so a CTU boundary never leaks a mode from the previous CTU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '1;
    else if (clr) q <= '1;
    else if (we)  q <= d;
  end
endmodule

module posi_mpm_rate_est #(
  parameter int LCU_LOG2 = 6,
  parameter int MIN_LOG2 = 3,
  parameter int MODE_W   = 6,
  parameter int COST_W   = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ctu_start_i,
  input  logic [5:0]              qp_i,
  input  logic                    req_valid_i,
  input  logic [2:0]              req_size_i,
  input  logic [2*(LCU_LOG2-2)-1:0] req_pos_i,
  input  logic [MODE_W-1:0]       req_mode_i,
  input  logic [4:0]              req_bits4x4_i,
  input  logic                    upd_valid_i,
  input  logic [2:0]              upd_size_i,
  input  logic [2*(LCU_LOG2-2)-1:0] upd_pos_i,
  input  logic [MODE_W-1:0]       upd_mode_i,
  output logic                    rate_valid_o,
  output logic [COST_W-1:0]       bitrate_o,
  output logic [1:0]              mpm_idx_o
);
  localparam int PW     = 2*(LCU_LOG2-2);
  localparam int GW     = LCU_LOG2-MIN_LOG2;
  localparam int N      = 1 << GW;
  localparam int STAGES = 2;
  localparam logic [MODE_W-1:0] INV = '1;

  // x lives on even Z-order bits, y on odd; the low bits inside a granule are dropped.
  function automatic logic [GW-1:0] gcoord(input logic [PW-1:0] pos, input int sel);
    logic [GW-1:0] g;
    g = '0;
    for (int k = 0; k < GW; k++) g[k] = pos[2*(k+MIN_LOG2-2)+sel];
    return g;
  endfunction

  function automatic logic [6:0] lambda_lut(input logic [5:0] qp);
    logic [6:0] l;
    case (qp)
      6'd16, 6'd17, 6'd18, 6'd19: l = 7'd2;
      6'd20, 6'd21, 6'd22:        l = 7'd3;
      6'd23, 6'd24, 6'd25:        l = 7'd4;
      6'd26:                      l = 7'd5;
      6'd27, 6'd28:               l = 7'd6;
      6'd29: l = 7'd7;   6'd30: l = 7'd8;   6'd31: l = 7'd9;   6'd32: l = 7'd10;
      6'd33: l = 7'd11;  6'd34: l = 7'd13;  6'd35: l = 7'd14;  6'd36: l = 7'd16;
      6'd37: l = 7'd18;  6'd38: l = 7'd20;  6'd39: l = 7'd23;  6'd40: l = 7'd25;
      6'd41: l = 7'd29;  6'd42: l = 7'd32;  6'd43: l = 7'd36;  6'd44: l = 7'd40;
      6'd45: l = 7'd45;  6'd46: l = 7'd51;  6'd47: l = 7'd57;  6'd48: l = 7'd64;
      6'd49: l = 7'd72;  6'd50: l = 7'd81;  6'd51: l = 7'd91;
      default: l = (qp < 6'd16) ? 7'd1 : 7'd0;
    endcase
    return l;
  endfunction

  logic unused_pos;
  assign unused_pos = ^{req_pos_i[2*(MIN_LOG2-2)-1:0], upd_pos_i[2*(MIN_LOG2-2)-1:0]};

  // ---------------- line buffers ----------------
  logic [N-1:0][MODE_W-1:0] top_q, lft_q;
  logic [N-1:0]             top_we, lft_we;
  logic [GW-1:0]            ugx, ugy, rgx, rgy;
  int                       upd_w;

  assign ugx = gcoord(upd_pos_i, 0);
  assign ugy = gcoord(upd_pos_i, 1);
  assign rgx = gcoord(req_pos_i, 0);
  assign rgy = gcoord(req_pos_i, 1);

  always_comb begin
    upd_w = 1;
    if (int'(upd_size_i) + 2 > MIN_LOG2) upd_w = 1 << (int'(upd_size_i) + 2 - MIN_LOG2);
  end

  for (genvar i = 0; i < N; i++) begin : g_ent
    assign top_we[i] = upd_valid_i && (i >= int'(ugx)) && (i < int'(ugx) + upd_w);
    assign lft_we[i] = upd_valid_i && (i >= int'(ugy)) && (i < int'(ugy) + upd_w);
    posi_mpm_lbuf_ent #(.MODE_W(MODE_W)) u_top (
      .clk(clk), .rst(rst), .clr(ctu_start_i), .we(top_we[i]), .d(upd_mode_i), .q(top_q[i]));
    posi_mpm_lbuf_ent #(.MODE_W(MODE_W)) u_lft (
      .clk(clk), .rst(rst), .clr(ctu_start_i), .we(lft_we[i]), .d(upd_mode_i), .q(lft_q[i]));
  end

  // ---------------- S1: neighbour fetch ----------------
  logic [STAGES:1]    vld_pipe;
  logic [MODE_W-1:0]  s1_a, s1_b, s1_mode;
  logic [6:0]         s1_lam;
  logic               s1_sz0;
  logic [4:0]         s1_b4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
      s1_lam   <= '0;
      s1_sz0   <= 1'b0;
      s1_b4    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], req_valid_i};
      if (req_valid_i) begin
        s1_a    <= (rgx == '0) ? INV : lft_q[rgy];
        s1_b    <= (rgy == '0) ? INV : top_q[rgx];
        s1_mode <= req_mode_i;
        s1_lam  <= lambda_lut(qp_i);
        s1_sz0  <= (req_size_i == 3'd0);
        s1_b4   <= req_bits4x4_i;
      end
    end
  end

  // ---------------- S2: MPM list and cost ----------------
  logic [MODE_W-1:0] na, nb, m0, m1, m2, sa, sb;
  logic [1:0]        idx;
  logic [4:0]        bits;
  logic [11:0]       prod;

  always_comb begin
    na = (s1_a == INV) ? MODE_W'(1) : s1_a;
    nb = (s1_b == INV) ? MODE_W'(1) : s1_b;
    sa = na + MODE_W'(29);
    sb = na - MODE_W'(1);
    m0 = na;
    m1 = nb;
    m2 = '0;
    if (na == nb) begin
      if (na < MODE_W'(2)) begin
        m0 = MODE_W'(0);
        m1 = MODE_W'(1);
        m2 = MODE_W'(26);
      end else begin
        m1 = MODE_W'(2) + MODE_W'(sa[4:0]);
        m2 = MODE_W'(2) + MODE_W'(sb[4:0]);
      end
    end else if (na != '0 && nb != '0) m2 = MODE_W'(0);
    else if (na != MODE_W'(1) && nb != MODE_W'(1)) m2 = MODE_W'(1);
    else m2 = MODE_W'(26);

    if (s1_mode == m0)      begin idx = 2'd0; bits = 5'd2; end
    else if (s1_mode == m1) begin idx = 2'd1; bits = 5'd3; end
    else if (s1_mode == m2) begin idx = 2'd2; bits = 5'd3; end
    else                    begin idx = 2'd3; bits = 5'd6; end
    if (s1_sz0) begin
      idx  = 2'd3;
      bits = s1_b4;
    end
    prod = 12'(s1_lam) * 12'(bits);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitrate_o <= '0;
      mpm_idx_o <= 2'd3;
    end else if (vld_pipe[STAGES-1]) begin
      bitrate_o <= COST_W'(prod);
      mpm_idx_o <= idx;
    end
  end

  assign rate_valid_o = vld_pipe[STAGES];
endmodule

// File: tb/tb_posi_mpm_rate_est.sv
// Directed bench for posi_mpm_rate_est: expected results are queued when a query is
// driven and checked, including arrival cycle, when the result strobe appears.

module tb_posi_mpm_rate_est;
  logic        clk = 1'b0;
  logic        rst;
  logic        ctu_start_i;
  logic [5:0]  qp_i;
  logic        req_valid_i;
  logic [2:0]  req_size_i;
  logic [7:0]  req_pos_i;
  logic [5:0]  req_mode_i;
  logic [4:0]  req_bits4x4_i;
  logic        upd_valid_i;
  logic [2:0]  upd_size_i;
  logic [7:0]  upd_pos_i;
  logic [5:0]  upd_mode_i;
  logic        rate_valid_o;
  logic [12:0] bitrate_o;
  logic [1:0]  mpm_idx_o;

  typedef struct {
    int          cyc;
    logic [12:0] rate;
    logic [1:0]  idx;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  posi_mpm_rate_est dut (
    .clk(clk), .rst(rst), .ctu_start_i(ctu_start_i), .qp_i(qp_i),
    .req_valid_i(req_valid_i), .req_size_i(req_size_i), .req_pos_i(req_pos_i),
    .req_mode_i(req_mode_i), .req_bits4x4_i(req_bits4x4_i),
    .upd_valid_i(upd_valid_i), .upd_size_i(upd_size_i), .upd_pos_i(upd_pos_i),
    .upd_mode_i(upd_mode_i), .rate_valid_o(rate_valid_o), .bitrate_o(bitrate_o),
    .mpm_idx_o(mpm_idx_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_out();
    exp_t e;
    if (rate_valid_o === 1'b1) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        assert (rate_valid_o === 1'b0) else begin
          n_fail++;
          $error("FAIL unexpected_valid: got valid=%b at cyc %0d, wanted 0", rate_valid_o, cyc);
        end
      end else begin
        e = sbq.pop_front();
        assert (cyc === e.cyc && bitrate_o === e.rate && mpm_idx_o === e.idx) else begin
          n_fail++;
          $error("FAIL %s: got cyc=%0d rate=%0d idx=%0d, wanted cyc=%0d rate=%0d idx=%0d",
                 e.tag, cyc, bitrate_o, mpm_idx_o, e.cyc, e.rate, e.idx);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_cmp++;
      assert (rate_valid_o === 1'b1) else begin
        n_fail++;
        $error("FAIL %s_missing: got valid=%b at cyc %0d, wanted 1", e.tag, rate_valid_o, cyc);
      end
    end
  endtask

  // Advance one cycle: drop strobes, then look at what the edge produced.
  task automatic nxt();
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    upd_valid_i = 1'b0;
    ctu_start_i = 1'b0;
    check_out();
  endtask

  task automatic drive_req(input logic [2:0] sz, input logic [7:0] pos, input logic [5:0] mode,
                           input logic [5:0] qp, input logic [4:0] b4);
    req_valid_i   = 1'b1;
    req_size_i    = sz;
    req_pos_i     = pos;
    req_mode_i    = mode;
    qp_i          = qp;
    req_bits4x4_i = b4;
  endtask

  task automatic req(input logic [2:0] sz, input logic [7:0] pos, input logic [5:0] mode,
                     input logic [5:0] qp, input logic [4:0] b4,
                     input logic [12:0] rate, input logic [1:0] idx, input string tag);
    exp_t e;
    drive_req(sz, pos, mode, qp, b4);
    e.cyc = cyc + 2;
    e.rate = rate;
    e.idx = idx;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic upd(input logic [2:0] sz, input logic [7:0] pos, input logic [5:0] mode);
    upd_valid_i = 1'b1;
    upd_size_i  = sz;
    upd_pos_i   = pos;
    upd_mode_i  = mode;
  endtask

  task automatic chk_idle(input logic [12:0] rate, input logic [1:0] idx, input string tag);
    n_cmp++;
    assert (rate_valid_o === 1'b0 && bitrate_o === rate && mpm_idx_o === idx) else begin
      n_fail++;
      $error("FAIL %s: got valid=%b rate=%0d idx=%0d, wanted valid=0 rate=%0d idx=%0d",
             tag, rate_valid_o, bitrate_o, mpm_idx_o, rate, idx);
    end
  endtask

  int qtab[19]   = '{0, 15, 16, 19, 22, 25, 26, 28, 29, 33, 34, 36, 39, 44, 47, 50, 51, 52, 63};
  int lamtab[19] = '{1,  1,  2,  2,  3,  4,  5,  6,  7, 11, 13, 16, 23, 40, 57, 81, 91,  0,  0};

  initial begin
    rst = 1'b1;
    ctu_start_i = 1'b0; qp_i = '0;
    req_valid_i = 1'b0; req_size_i = '0; req_pos_i = '0; req_mode_i = '0; req_bits4x4_i = '0;
    upd_valid_i = 1'b0; upd_size_i = '0; upd_pos_i = '0; upd_mode_i = '0;
    repeat (3) nxt();
    chk_idle(13'd0, 2'd3, "reset_state");
    rst = 1'b0;
    nxt();

    // 1: empty neighbours -> {0,1,26}, mode 26 at idx2, lambda 10
    req(3'd1, 8'h00, 6'd26, 6'd32, 5'd0, 13'd30, 2'd2, "t1_dc_list");
    nxt();

    // 2: left neighbour 10, top outside the CTU
    upd(3'd1, 8'h00, 6'd10);
    nxt();
    req(3'd1, 8'h04, 6'd10, 6'd26, 5'd0, 13'd10, 2'd0, "t2_left_only");
    nxt();

    // 3: both neighbours 10 -> {10,9,11}
    upd(3'd1, 8'h08, 6'd10);
    nxt();
    upd(3'd1, 8'h04, 6'd10);
    nxt();
    req(3'd1, 8'h0C, 6'd9,  6'd22, 5'd0, 13'd9,  2'd1, "t3_mode9");
    nxt();
    req(3'd1, 8'h0C, 6'd11, 6'd22, 5'd0, 13'd9,  2'd2, "t3_mode11");
    nxt();
    req(3'd1, 8'h0C, 6'd20, 6'd22, 5'd0, 13'd18, 2'd3, "t3_mode20_miss");
    nxt();

    // 4: 32x32 update spans granules 0..3 -> {5,4,6}; then clear wins over same-cycle update
    upd(3'd3, 8'h00, 6'd5);
    nxt();
    req(3'd1, 8'h0C, 6'd5, 6'd30, 5'd0, 13'd16, 2'd0, "t4_wide_upd");
    nxt();
    ctu_start_i = 1'b1;
    upd(3'd1, 8'h0C, 6'd5);
    nxt();
    req(3'd1, 8'h0C, 6'd5, 6'd30, 5'd0, 13'd48, 2'd3, "t4_after_clear");
    nxt();

    // 5: back-to-back 4x4 queries
    for (int i = 0; i < 4; i++) begin
      req(3'd0, 8'(i), 6'd7, 6'd51, 5'd17, 13'd1547, 2'd3, "t5_b2b_qp51");
      nxt();
    end
    req(3'd0, 8'h00, 6'd7, 6'd52, 5'd17, 13'd0, 2'd3, "t5_qp52");
    nxt();

    // lambda table corners via 4x4 queries with one bit
    for (int i = 0; i < 19; i++) begin
      req(3'd0, 8'h00, 6'd0, 6'(qtab[i]), 5'd1, 13'(lamtab[i]), 2'd3, $sformatf("lambda_qp%0d", qtab[i]));
      nxt();
    end

    // 6: same-cycle update is invisible to the query, visible to the next one
    upd(3'd1, 8'h0C, 6'd20);
    req(3'd1, 8'h0C, 6'd20, 6'd30, 5'd0, 13'd48, 2'd3, "t6_same_cycle_old");
    nxt();
    req(3'd1, 8'h0C, 6'd20, 6'd30, 5'd0, 13'd16, 2'd0, "t6_next_new");
    nxt();
    repeat (3) nxt();
    chk_idle(13'd16, 2'd0, "t6_hold");

    // reset while a query sits in S1: no result may appear
    drive_req(3'd1, 8'h0C, 6'd20, 6'd30, 5'd0);
    nxt();
    rst = 1'b1;
    #1;
    chk_idle(13'd0, 2'd3, "t6_async_reset");
    nxt();
    nxt();
    rst = 1'b0;
    repeat (3) nxt();
    req(3'd1, 8'h0C, 6'd20, 6'd30, 5'd0, 13'd48, 2'd3, "t6_bufs_reset");
    nxt();

    repeat (4) nxt();
    n_cmp++;
    assert (sbq.size() === 0) else begin
      n_fail++;
      $error("FAIL drain: got %0d pending results, wanted 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
